param_divider: RTL and testbench

PARAM_DIVIDER -- requirements
Module: param_divider

---
 rtl/param_divider.sv | 161 ++++++++++++++++
 tb/tb_param_divider.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/param_divider.sv
// Sequential restoring divider: N-bit dividend by M-bit divisor, one quotient bit per clock.
// Optional two's-complement mode is compiled in with `define DIVIDER_SIGNED_EN (adds input signed_mode).
module param_divider #(
  parameter int N = 8,
  parameter int M = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] dividendin,
  input  logic [M-1:0] divisorin,
`ifdef DIVIDER_SIGNED_EN
  input  logic         signed_mode,
`endif
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [M-1:0] remainder,
  output logic         divzero
);

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | N shift/subtract iterations on the captured operands
  // DONE  | results valid for one cycle; start here chains the next operation
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam int CW = $clog2(N + 1);

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   dvd_q, dvd_d;
  logic [M-1:0]   dvs_q, dvs_d;
  logic [M-1:0]   rem_q, rem_d;
  logic           neg_quo_q, neg_quo_d;
  logic           neg_rem_q, neg_rem_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [N-1:0]   quotient_q, quotient_d;
  logic [M-1:0]   remainder_q, remainder_d;
  logic           divzero_q, divzero_d;

  logic           smode;
  logic           a_neg, b_neg;
  logic [N-1:0]   a_mag;
  logic [M-1:0]   b_mag;
  logic [M:0]     shifted;
  logic [M+1:0]   trial;
  logic           qbit;
  logic [M-1:0]   rem_next;
  logic [N-1:0]   dvd_next;
  logic [N-1:0]   quo_fin;
  logic [M-1:0]   rem_fin;
  logic           accept;

`ifdef DIVIDER_SIGNED_EN
  assign smode = signed_mode;
`else
  assign smode = 1'b0;
`endif

  // Operands are reduced to magnitudes at capture; -2^(N-1) still fits as unsigned.
  assign a_neg = smode & dividendin[N-1];
  assign b_neg = smode & divisorin[M-1];
  assign a_mag = a_neg ? -dividendin : dividendin;
  assign b_mag = b_neg ? -divisorin  : divisorin;

  // One restoring step; the extra top bit of trial is the borrow.
  assign shifted  = {rem_q, dvd_q[N-1]};
  assign trial    = {1'b0, shifted} - {2'b00, dvs_q};
  assign qbit     = ~trial[M+1];
  assign rem_next = qbit ? trial[M-1:0] : shifted[M-1:0];
  assign dvd_next = {dvd_q[N-2:0], qbit};

  assign quo_fin  = neg_quo_q ? -dvd_next : dvd_next;
  assign rem_fin  = neg_rem_q ? -rem_next : rem_next;

  assign accept   = start && (state_q != S_RUN);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    divzero_d   = divzero_q;

    if (accept) begin
      cnt_d     = '0;
      dvd_d     = a_mag;
      dvs_d     = b_mag;
      rem_d     = '0;
      neg_quo_d = a_neg ^ b_neg;
      neg_rem_d = a_neg;
      if (divisorin == '0) begin
        state_d     = S_DONE;
        quotient_d  = '1;
        remainder_d = dividendin[M-1:0];
        divzero_d   = 1'b1;
      end else begin
        state_d   = S_RUN;
        divzero_d = 1'b0;
      end
    end else if (state_q == S_RUN) begin
      dvd_d = dvd_next;
      rem_d = rem_next;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(N - 1)) begin
        state_d     = S_DONE;
        quotient_d  = quo_fin;
        remainder_d = rem_fin;
      end
    end else if (state_q == S_DONE) begin
      state_d = S_IDLE;
    end

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      divzero_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      divzero_q   <= divzero_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign divzero   = divzero_q;

endmodule

// File: tb/tb_param_divider.sv
// Directed bench for param_divider (N=8, M=7) with hand-computed expected results.
module tb_param_divider;
  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] dividendin;
  logic [6:0] divisorin;
  logic       busy, done, divzero;
  logic [7:0] quotient;
  logic [6:0] remainder;
`ifdef DIVIDER_SIGNED_EN
  logic       signed_mode = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  param_divider #(.N(8), .M(7)) dut (
    .clk(clk), .reset(reset), .start(start),
    .dividendin(dividendin), .divisorin(divisorin),
`ifdef DIVIDER_SIGNED_EN
    .signed_mode(signed_mode),
`endif
    .busy(busy), .done(done), .quotient(quotient),
    .remainder(remainder), .divzero(divzero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Launch an operation and count edges after E0 until done; busy_cnt counts cycles with busy high.
  task automatic run_op(input logic [7:0] a, input logic [6:0] b,
                        output int lat, output int busy_cnt);
    @(negedge clk);
    start = 1'b1; dividendin = a; divisorin = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (busy) busy_cnt++;
    end
  endtask

  int lat, bcnt, seen;

  initial begin
    reset = 1'b1; start = 1'b0; dividendin = '0; divisorin = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quo", quotient, 0);
    chk("rst_rem", remainder, 0);
    chk("rst_dz", divzero, 0);
    reset = 1'b0;

    run_op(8'd200, 7'd7, lat, bcnt);
    chk("200/7_lat", lat, 8);
    chk("200/7_busy_cycles", bcnt, 8);
    chk("200/7_quo", quotient, 28);
    chk("200/7_rem", remainder, 4);
    chk("200/7_dz", divzero, 0);
    @(posedge clk); #1;
    chk("done_pulse_width", done, 0);
    chk("idle_busy", busy, 0);
    chk("hold_quo", quotient, 28);

    run_op(8'd5, 7'd0, lat, bcnt);
    chk("5/0_lat", lat, 0);
    chk("5/0_busy", bcnt, 0);
    chk("5/0_dz", divzero, 1);
    chk("5/0_quo", quotient, 8'hFF);
    chk("5/0_rem", remainder, 5);
    @(posedge clk); #1;
    chk("5/0_dz_hold", divzero, 1);
    chk("5/0_done_clear", done, 0);

    run_op(8'd255, 7'd1, lat, bcnt);
    chk("255/1_quo", quotient, 255);
    chk("255/1_rem", remainder, 0);
    chk("255/1_dz", divzero, 0);

    run_op(8'd255, 7'd127, lat, bcnt);
    chk("255/127_quo", quotient, 2);
    chk("255/127_rem", remainder, 1);
    run_op(8'd6, 7'd7, lat, bcnt);
    chk("6/7_quo", quotient, 0);
    chk("6/7_rem", remainder, 6);
    run_op(8'd13, 7'd13, lat, bcnt);
    chk("13/13_quo", quotient, 1);
    chk("13/13_rem", remainder, 0);

    // back-to-back: start held during DONE of 200/7
    run_op(8'd200, 7'd7, lat, bcnt);
    chk("b2b_first_quo", quotient, 28);
    start = 1'b1; dividendin = 8'd100; divisorin = 7'd10;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_no_idle", busy, 1);
    chk("b2b_done_low", done, 0);
    lat = 0;
    while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("b2b_lat", lat, 8);
    chk("b2b_quo", quotient, 10);
    chk("b2b_rem", remainder, 0);

    // start pulsed mid-RUN is ignored
    @(negedge clk);
    start = 1'b1; dividendin = 8'd200; divisorin = 7'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; dividendin = 8'd100; divisorin = 7'd10;
    @(posedge clk); #1;
    start = 1'b0; dividendin = 8'd9; divisorin = 7'd2;
    lat = 4;
    while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("ign_lat", lat, 8);
    chk("ign_quo", quotient, 28);
    chk("ign_rem", remainder, 4);

    // reset after 3 RUN edges
    @(negedge clk);
    start = 1'b1; dividendin = 8'd200; divisorin = 7'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_quo", quotient, 0);
    chk("mid_rst_rem", remainder, 0);
    chk("mid_rst_dz", divzero, 0);
    seen = 0;
    repeat (12) begin @(posedge clk); #1; if (done || busy) seen++; end
    chk("mid_rst_no_done", seen, 0);
    run_op(8'd200, 7'd7, lat, bcnt);
    chk("post_rst_lat", lat, 8);
    chk("post_rst_quo", quotient, 28);
    chk("post_rst_rem", remainder, 4);

`ifdef DIVIDER_SIGNED_EN
    signed_mode = 1'b1;
    run_op(8'h9C, 7'd7, lat, bcnt);
    chk("s_-100/7_lat", lat, 8);
    chk("s_-100/7_quo", quotient, 8'hF2);
    chk("s_-100/7_rem", remainder, 7'h7E);
    run_op(8'h80, 7'h7F, lat, bcnt);
    chk("s_ovf_quo", quotient, 8'h80);
    chk("s_ovf_rem", remainder, 0);
    signed_mode = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
